ray_bounce_ctrl: RTL
====================

RAY_BOUNCE_CTRL -- requirements
Module: ray_bounce_ctrl

Interface
REQ-001 SHALL have parameter MAX_BOUNCES, default 4, maximum reflections per path (1..15).
REQ-002 SHALL have parameter ADDR_W, default 17, pixel address width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 pix_valid/pix_ready  input/output  1/1  new primary ray handshake.
REQ-006 pix_origin, pix_dir  input  fp24_vec3 each  primary ray; pix_addr  input  ADDR_W  pixel address.
REQ-007 trace_valid/trace_ready  output/input  1/1  ray issue handshake to intersector.
REQ-008 trace_origin, trace_dir  output  fp24_vec3; trace_color, trace_income  output  fp24_color  current path state.
REQ-009 trace_hit, trace_miss  input  1 each  one-cycle intersector result pulses.
REQ-010 rflx_done  input  1; rflx_dir, rflx_origin  input  fp24_vec3; rflx_color, rflx_income  input  fp24_color  reflector results.
REQ-011 px_valid/px_ready  output/input  1/1; px_addr  output  ADDR_W; px_light  output  fp24_color  finished pixel.
REQ-012 busy  output  1  high in any state except IDLE.

Function
REQ-013 SHALL implement FSM IDLE, ISSUE, WAIT_HIT, WAIT_RFLX, EMIT.
REQ-014 IDLE: pix_ready=1; on pix_valid latch origin/dir/addr, color<=1.0 per channel, income<=0, bounce<=0, go ISSUE.
REQ-015 ISSUE: trace_valid=1 with latched state; on trace_ready go WAIT_HIT; outputs stable while trace_valid high and not ready.
REQ-016 WAIT_HIT: trace_miss go EMIT; trace_hit go WAIT_RFLX; both same cycle: miss wins.
REQ-017 WAIT_RFLX: on rflx_done latch rflx_* into path state, bounce<=bounce+1; if new bounce==MAX_BOUNCES go EMIT else ISSUE.
REQ-018 EMIT: px_valid=1, px_light=latched income, px_addr=latched addr; on px_ready go IDLE; stable while stalled.
REQ-019 trace_hit/trace_miss/rflx_done outside their wait states SHALL be ignored with no state change.
REQ-020 pix_ready SHALL be 0 in every state but IDLE; at most one path in flight.
REQ-021 bounce counter 4-bit, never wraps; saturation impossible given REQ-017.
REQ-022 Primary-ray miss SHALL emit income 0 (black).
REQ-023 No arithmetic on fp24 data; block only stores and forwards.

Reset
REQ-024 On rst low: state IDLE, pix_ready 1 (after deassert), trace_valid 0, px_valid 0, busy 0, all latched data and counters 0, immediately and asynchronously.
REQ-025 Reset mid-path SHALL abandon path; no px_valid produced for it.

Configuration
REQ-026 With RAY_BOUNCE_STATS_EN defined: outputs stat_rays (32b, increments per trace handshake) and stat_pixels (32b, per px handshake), both wrap, reset 0.
REQ-027 Without RAY_BOUNCE_STATS_EN: ports and counters absent; behaviour otherwise identical.

Structure
REQ-028 fp24_vec3, fp24_color, fp24 1.0 constant and FSM state enum SHALL live in the shared rtx package.
REQ-029 Single module; no sub-module required.

Verification
REQ-030 pix (addr 5), immediate trace_miss -> one px_valid, addr 5, light 0, 1 trace issued.
REQ-031 MAX_BOUNCES=4, always hit, rflx_income=0.5 per channel -> exactly 4 trace issues, px_light 0.5, busy low after px_ready.
REQ-032 hit, hit, miss with rflx_income 0.25 then 0.75 -> 3 issues, px_light 0.75.
REQ-033 trace_ready held low 10 cycles, px_ready low 10 cycles -> trace_*/px_* stable throughout, no duplicate handshake.
REQ-034 rst low in WAIT_RFLX, then rflx_done -> no px_valid, IDLE, pix_ready 1.
REQ-035 Simultaneous trace_hit and trace_miss -> EMIT; stray rflx_done in IDLE -> ignored; stat_rays counts correct with macro.

Source files
------------

// File: rtl/rtx_pkg.sv
// rtx_pkg: shared fp24 ray-tracing types, constants and the bounce controller state enum.
// fp24 layout is 1 sign, 7 exponent (bias 63), 16 mantissa bits.
package rtx_pkg;

    typedef logic [23:0] fp24_t;

    typedef struct packed {
        fp24_t x;
        fp24_t y;
        fp24_t z;
    } fp24_vec3;

    typedef struct packed {
        fp24_t r;
        fp24_t g;
        fp24_t b;
    } fp24_color;

    localparam fp24_t     FP24_ONE   = 24'h3F0000;
    localparam fp24_color FP24_WHITE = '{r: FP24_ONE, g: FP24_ONE, b: FP24_ONE};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HIT,
        S_WAIT_RFLX,
        S_EMIT
    } rbc_state_e;

endpackage

// File: rtl/ray_bounce_ctrl.sv
// ray_bounce_ctrl: walks one primary ray through up to MAX_BOUNCES reflections and emits its light.
// Define RAY_BOUNCE_STATS_EN to add the stat_rays / stat_pixels handshake counters.
module ray_bounce_ctrl
    import rtx_pkg::*;
#(
    parameter int MAX_BOUNCES = 4,
    parameter int ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  fp24_vec3          pix_origin,
    input  fp24_vec3          pix_dir,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic              trace_valid,
    input  logic              trace_ready,
    output fp24_vec3          trace_origin,
    output fp24_vec3          trace_dir,
    output fp24_color         trace_color,
    output fp24_color         trace_income,
    input  logic              trace_hit,
    input  logic              trace_miss,
    input  logic              rflx_done,
    input  fp24_vec3          rflx_dir,
    input  fp24_vec3          rflx_origin,
    input  fp24_color         rflx_color,
    input  fp24_color         rflx_income,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [ADDR_W-1:0] px_addr,
    output fp24_color         px_light,
    output logic              busy
`ifdef RAY_BOUNCE_STATS_EN
    ,
    output logic [31:0]       stat_rays,
    output logic [31:0]       stat_pixels
`endif
);

    rbc_state_e        state_q, state_d;
    fp24_vec3          origin_q, origin_d, dir_q, dir_d;
    fp24_color         color_q, color_d, income_q, income_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        bounce_q, bounce_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            origin_q <= '0;
            dir_q    <= '0;
            color_q  <= '0;
            income_q <= '0;
            addr_q   <= '0;
            bounce_q <= '0;
        end else begin
            state_q  <= state_d;
            origin_q <= origin_d;
            dir_q    <= dir_d;
            color_q  <= color_d;
            income_q <= income_d;
            addr_q   <= addr_d;
            bounce_q <= bounce_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        origin_d = origin_q;
        dir_d    = dir_q;
        color_d  = color_q;
        income_d = income_q;
        addr_d   = addr_q;
        bounce_d = bounce_q;
        case (state_q)
            S_IDLE: if (pix_valid) begin
                origin_d = pix_origin;
                dir_d    = pix_dir;
                addr_d   = pix_addr;
                color_d  = FP24_WHITE;
                income_d = '0;
                bounce_d = '0;
                state_d  = S_ISSUE;
            end
            S_ISSUE:    state_d = trace_ready ? S_WAIT_HIT : S_ISSUE;
            // a miss reported together with a hit terminates the path
            S_WAIT_HIT: state_d = trace_miss ? S_EMIT : (trace_hit ? S_WAIT_RFLX : S_WAIT_HIT);
            S_WAIT_RFLX: if (rflx_done) begin
                origin_d = rflx_origin;
                dir_d    = rflx_dir;
                color_d  = rflx_color;
                income_d = rflx_income;
                bounce_d = bounce_q + 4'd1;
                state_d  = (bounce_d == 4'(MAX_BOUNCES)) ? S_EMIT : S_ISSUE;
            end
            S_EMIT:     state_d = px_ready ? S_IDLE : S_EMIT;
            default:    state_d = S_IDLE;
        endcase
    end

    assign pix_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign trace_valid  = (state_q == S_ISSUE);
    assign px_valid     = (state_q == S_EMIT);
    assign trace_origin = origin_q;
    assign trace_dir    = dir_q;
    assign trace_color  = color_q;
    assign trace_income = income_q;
    assign px_addr      = addr_q;
    assign px_light     = income_q;

`ifdef RAY_BOUNCE_STATS_EN
    logic [31:0] rays_q, pixels_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rays_q   <= '0;
            pixels_q <= '0;
        end else begin
            rays_q   <= rays_q + 32'(trace_valid && trace_ready);
            pixels_q <= pixels_q + 32'(px_valid && px_ready);
        end
    end

    assign stat_rays   = rays_q;
    assign stat_pixels = pixels_q;
`endif

endmodule
